inyector_paquetes: RTL and testbench
====================================

INYECTOR_PAQUETES -- requirements
Module: inyector_paquetes

Interface
REQ-001 The block SHALL have parameter X_LOCAL, default 1, node X address placed in header source field.
REQ-002 The block SHALL have parameter Y_LOCAL, default 1, node Y address placed in header source field.
REQ-003 The block SHALL have parameter CREDITS, default `BUFFER_DEPTH/5 (4), packet slots in downstream buffer.
REQ-004 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port pkt_valid_din, input, 1, local source requests one packet.
REQ-007 The block SHALL have port pkt_dest_x_din, input, 3, destination X.
REQ-008 The block SHALL have port pkt_dest_y_din, input, 3, destination Y.
REQ-009 The block SHALL have port pkt_ready_dout, output, 1, one-cycle accept pulse.
REQ-010 The block SHALL have port flit_data_din, input, `CHANNEL_WIDTH, current data flit from source.
REQ-011 The block SHALL have port flit_read_dout, output, 1, source advances to next flit on the edge where this is high.
REQ-012 The block SHALL have port channel_dout, output, `CHANNEL_WIDTH, registered network channel.
REQ-013 The block SHALL have port credit_in_din, input, 1, one-cycle pulse returning one packet slot.
REQ-014 The block SHALL have port busy_dout, output, 1, high while a packet is on the channel.
REQ-015 The block SHALL have port credit_error_dout, output, 1, sticky credit overflow flag (see Configuration).

Function
REQ-016 Packet SHALL be 1 header flit followed by `DATA_FLITS data flits on consecutive cycles, no bubbles.
REQ-017 FSM SHALL have states IDLE, HEADER, DATA.
REQ-018 IDLE->HEADER SHALL occur when pkt_valid_din=1 and credit_reg!=0; otherwise remain IDLE.
REQ-019 On that transition pkt_ready_dout SHALL be high for that cycle only; dest inputs sampled at that edge.
REQ-020 Header flit SHALL carry `HEADER_FIELD=1, `WITNESS_FIELD=0, [29:27]=dest X, [26:24]=dest Y, [23:21]=X_LOCAL, [20:18]=Y_LOCAL, remaining bits 0.
REQ-021 Header SHALL appear on channel_dout the cycle after the accepting edge (latency 1).
REQ-022 HEADER->DATA unconditionally; flit counter (width clog2(`DATA_FLITS)+1) loaded with `DATA_FLITS.
REQ-023 In every cycle whose following edge registers a data flit, flit_read_dout SHALL be 1; registered flit = flit_data_din with `HEADER_FIELD forced 0.
REQ-024 Counter SHALL decrement per data flit; on last data flit FSM SHALL go HEADER if pkt_valid_din=1 and credit_reg!=0 (back-to-back, pkt_ready_dout pulses), else IDLE.
REQ-025 channel_dout SHALL be all zeros in every cycle no flit is driven.
REQ-026 credit_reg SHALL decrement by 1 on each header launch, increment by 1 on credit_in_din; both same cycle -> unchanged.
REQ-027 A credit_in_din arriving in the same cycle credit_reg=0 SHALL NOT enable launch that cycle; launch evaluated next cycle.
REQ-028 credit_in_din with credit_reg=CREDITS and no simultaneous launch SHALL be ignored (saturate).
REQ-029 busy_dout SHALL be 1 exactly in cycles channel_dout holds a header or data flit.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE, credit_reg=CREDITS, counter=`DATA_FLITS, channel_dout=0, pkt_ready_dout=0, flit_read_dout=0, busy_dout=0, credit_error_dout=0.
REQ-031 Reset mid-packet SHALL abandon the packet; no remaining flits emitted after release.
REQ-032 First launch SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-033 With `INYECTOR_CREDIT_ERR_EN defined, credit_error_dout SHALL set on any ignored credit per REQ-028 and hold until reset.
REQ-034 Without `INYECTOR_CREDIT_ERR_EN, credit_error_dout SHALL be constant 0 and no flag register built.

Verification (`DATA_FLITS=4, `CHANNEL_WIDTH=32, CREDITS=4)
REQ-035 Single packet dest (2,3), X_LOCAL=1,Y_LOCAL=1 -> header [29:24]=6'b010011, [23:18]=6'b001001, then 4 data flits, then zeros; credit_reg 4->3.
REQ-036 pkt_valid_din held high, no credits returned -> exactly 4 back-to-back packets (20 flits contiguous), then channel zero, pkt_ready_dout stays 0.
REQ-037 credit_reg=0, credit_in_din pulse -> header launched one cycle later than the credit pulse edge, credit_reg 1->0.
REQ-038 Launch and credit_in_din in same cycle at credit_reg=2 -> credit_reg remains 2.
REQ-039 credit_in_din at credit_reg=4 -> credit_reg stays 4; credit_error_dout=1 with macro, 0 without.
REQ-040 reset asserted during 2nd data flit -> channel_dout=0 same cycle, no further flits, credit_reg=4 after release.

Source files
------------

// File: rtl/inyector_paquetes.sv
// Packet injector: emits a header plus `DATA_FLITS data flits per credit onto a registered channel.
// Optional sticky credit-overflow flag enabled by defining INYECTOR_CREDIT_ERR_EN.

`ifndef DATA_FLITS
`define DATA_FLITS 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 32
`endif
`ifndef HEADER_FIELD
`define HEADER_FIELD 31
`endif
`ifndef WITNESS_FIELD
`define WITNESS_FIELD 30
`endif
`ifndef BUFFER_DEPTH
`define BUFFER_DEPTH 20
`endif

module inyector_paquetes #(
    parameter int unsigned X_LOCAL = 1,
    parameter int unsigned Y_LOCAL = 1,
    parameter int unsigned CREDITS = `BUFFER_DEPTH / 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pkt_valid_din,
    input  logic [2:0]                pkt_dest_x_din,
    input  logic [2:0]                pkt_dest_y_din,
    output logic                      pkt_ready_dout,
    input  logic [`CHANNEL_WIDTH-1:0] flit_data_din,
    output logic                      flit_read_dout,
    output logic [`CHANNEL_WIDTH-1:0] channel_dout,
    input  logic                      credit_in_din,
    output logic                      busy_dout,
    output logic                      credit_error_dout
);

    localparam int unsigned CW    = `CHANNEL_WIDTH;
    localparam int unsigned CntW  = $clog2(`DATA_FLITS) + 1;
    localparam int unsigned CredW = $clog2(CREDITS + 1);

    localparam logic [CntW-1:0]  FlitsInit = CntW'(`DATA_FLITS);
    localparam logic [CredW-1:0] CredMax   = CredW'(CREDITS);

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StData
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CredW-1:0] credit_q, credit_d;
    logic [CW-1:0]    chan_q, chan_d;

    logic             launch;
    logic             flit_read;
    logic             credit_drop;
    logic             can_launch;
    logic [CW-1:0]    header_flit;
    logic [CW-1:0]    data_flit;

    always_comb begin
        header_flit                 = '0;
        header_flit[`HEADER_FIELD]  = 1'b1;
        header_flit[`WITNESS_FIELD] = 1'b0;
        header_flit[29:27]          = pkt_dest_x_din;
        header_flit[26:24]          = pkt_dest_y_din;
        header_flit[23:21]          = 3'(X_LOCAL);
        header_flit[20:18]          = 3'(Y_LOCAL);

        data_flit                   = flit_data_din;
        data_flit[`HEADER_FIELD]    = 1'b0;
    end

    // Gating with reset keeps the accept pulse low while the block is held in reset.
    assign can_launch = reset && pkt_valid_din && (credit_q != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chan_d    = '0;
        launch    = 1'b0;
        flit_read = 1'b0;

        case (state_q)
            StIdle: begin
                launch = can_launch;
            end
            StHeader: begin
                flit_read = 1'b1;
                chan_d    = data_flit;
                cnt_d     = cnt_q - 1'b1;
                state_d   = StData;
            end
            StData: begin
                if (cnt_q != '0) begin
                    flit_read = 1'b1;
                    chan_d    = data_flit;
                    cnt_d     = cnt_q - 1'b1;
                end else begin
                    // Last data flit is on the channel: chain the next packet without a bubble.
                    state_d = StIdle;
                    launch  = can_launch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (launch) begin
            state_d = StHeader;
            chan_d  = header_flit;
            cnt_d   = FlitsInit;
        end
    end

    always_comb begin
        credit_d    = credit_q;
        credit_drop = 1'b0;
        if (launch && !credit_in_din) begin
            credit_d = credit_q - 1'b1;
        end else if (!launch && credit_in_din) begin
            if (credit_q < CredMax) begin
                credit_d = credit_q + 1'b1;
            end else begin
                credit_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= FlitsInit;
            credit_q <= CredMax;
            chan_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            chan_q   <= chan_d;
        end
    end

    assign pkt_ready_dout = launch;
    assign flit_read_dout = flit_read;
    assign channel_dout   = chan_q;
    assign busy_dout      = (state_q != StIdle);

`ifdef INYECTOR_CREDIT_ERR_EN
    logic credit_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_err_q <= 1'b0;
        end else if (credit_drop) begin
            credit_err_q <= 1'b1;
        end
    end

    assign credit_error_dout = credit_err_q;
`else
    logic unused_credit_drop;
    assign unused_credit_drop = credit_drop;
    assign credit_error_dout  = 1'b0;
`endif

endmodule

// File: tb/tb_inyector_paquetes.sv
// Randomized self-checking bench for inyector_paquetes against a flit-queue reference model.

`ifndef DATA_FLITS
`define DATA_FLITS 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 32
`endif
`ifndef HEADER_FIELD
`define HEADER_FIELD 31
`endif

module tb_inyector_paquetes;

    localparam int unsigned XL    = 1;
    localparam int unsigned YL    = 1;
    localparam int unsigned NCRED = 4;
    localparam int unsigned NF    = `DATA_FLITS;
    localparam int unsigned W     = `CHANNEL_WIDTH;

    logic         clk;
    logic         reset;
    logic         pkt_valid_din;
    logic [2:0]   pkt_dest_x_din;
    logic [2:0]   pkt_dest_y_din;
    logic         pkt_ready_dout;
    logic [W-1:0] flit_data_din;
    logic         flit_read_dout;
    logic [W-1:0] channel_dout;
    logic         credit_in_din;
    logic         busy_dout;
    logic         credit_error_dout;

    inyector_paquetes #(
        .X_LOCAL(XL),
        .Y_LOCAL(YL),
        .CREDITS(NCRED)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pkt_valid_din    (pkt_valid_din),
        .pkt_dest_x_din   (pkt_dest_x_din),
        .pkt_dest_y_din   (pkt_dest_y_din),
        .pkt_ready_dout   (pkt_ready_dout),
        .flit_data_din    (flit_data_din),
        .flit_read_dout   (flit_read_dout),
        .channel_dout     (channel_dout),
        .credit_in_din    (credit_in_din),
        .busy_dout        (busy_dout),
        .credit_error_dout(credit_error_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: credits, data flits still owed for the current packet, expected channel.
    int           m_credits;
    int           m_left;
    bit           m_busy;
    bit           m_err;
    logic [W-1:0] m_chan;

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_header(input logic [2:0] dx, input logic [2:0] dy);
        logic [W-1:0] h;
        h = (W'(1) << `HEADER_FIELD) | (W'(dx) << 27) | (W'(dy) << 24)
            | (W'(XL) << 21) | (W'(YL) << 18);
        return h;
    endfunction

    function automatic bit exp_err();
`ifdef INYECTOR_CREDIT_ERR_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_credits = NCRED;
        m_left    = 0;
        m_busy    = 1'b0;
        m_err     = 1'b0;
        m_chan    = '0;
    endtask

    task automatic step(input bit v, input logic [2:0] dx, input logic [2:0] dy,
                        input logic [W-1:0] d, input bit cr);
        bit launch_e;
        bit read_e;
        @(negedge clk);
        pkt_valid_din  = v;
        pkt_dest_x_din = dx;
        pkt_dest_y_din = dy;
        flit_data_din  = d;
        credit_in_din  = cr;
        #1;
        read_e   = (m_left > 0);
        launch_e = !read_e && v && (m_credits > 0);
        check_eq("pkt_ready", W'(pkt_ready_dout), W'(launch_e));
        check_eq("flit_read", W'(flit_read_dout), W'(read_e));
        @(posedge clk);
        if (read_e) begin
            m_left--;
            m_chan                = d;
            m_chan[`HEADER_FIELD] = 1'b0;
            m_busy                = 1'b1;
        end else if (launch_e) begin
            m_left = NF;
            m_chan = exp_header(dx, dy);
            m_busy = 1'b1;
        end else begin
            m_chan = '0;
            m_busy = 1'b0;
        end
        if (launch_e && !cr) begin
            m_credits--;
        end else if (cr && !launch_e) begin
            if (m_credits < NCRED) m_credits++;
            else m_err = 1'b1;
        end
        #1;
        check_eq("channel", channel_dout, m_chan);
        check_eq("busy", W'(busy_dout), W'(m_busy));
        check_eq("credit_err", W'(credit_error_dout), W'(exp_err()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, W'($urandom), 1'b0);
    endtask

    // Holds valid high with no credits returned and counts cycles with a flit on the channel.
    task automatic hold_valid(input int n, output int flits);
        flits = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), W'($urandom), 1'b0);
            if (busy_dout) flits++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset         = 1'b0;
        pkt_valid_din = 1'b1;
        #1;
        check_eq("rst_channel", channel_dout, '0);
        check_eq("rst_busy", W'(busy_dout), '0);
        check_eq("rst_ready", W'(pkt_ready_dout), '0);
        check_eq("rst_read", W'(flit_read_dout), '0);
        check_eq("rst_err", W'(credit_error_dout), '0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    int flits;

    initial begin
        reset          = 1'b0;
        pkt_valid_din  = 1'b1;
        pkt_dest_x_din = '0;
        pkt_dest_y_din = '0;
        flit_data_din  = '0;
        credit_in_din  = 1'b0;
        model_reset();
        #12;
        check_eq("init_channel", channel_dout, '0);
        check_eq("init_ready", W'(pkt_ready_dout), '0);
        check_eq("init_busy", W'(busy_dout), '0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Single packet to (2,3), launched on the first edge after reset release.
        step(1'b1, 3'd2, 3'd3, W'($urandom), 1'b0);
        check_eq("hdr_dest", W'(channel_dout[29:24]), W'(6'b010011));
        check_eq("hdr_src", W'(channel_dout[23:18]), W'(6'b001001));
        idle(NF + 3);

        // Back-to-back packets until the credits run out.
        do_reset();
        hold_valid(30, flits);
        check_eq("b2b_flits", W'(flits), W'(NCRED * (NF + 1)));

        // Credit returned at zero: launch follows on the next edge, not the same one.
        step(1'b1, 3'd5, 3'd6, W'($urandom), 1'b1);
        check_eq("zero_credit_no_launch", W'(busy_dout), '0);
        step(1'b1, 3'd5, 3'd6, W'($urandom), 1'b0);
        check_eq("credit_launch_hdr", channel_dout, exp_header(3'd5, 3'd6));
        hold_valid(12, flits);
        check_eq("credit_one_packet", W'(flits), W'(NF));

        // Launch with a simultaneous credit return at two credits left.
        do_reset();
        step(1'b1, 3'd1, 3'd1, W'($urandom), 1'b0);
        idle(NF + 1);
        step(1'b1, 3'd1, 3'd2, W'($urandom), 1'b0);
        idle(NF + 1);
        step(1'b1, 3'd3, 3'd4, W'($urandom), 1'b1);
        idle(NF + 1);
        hold_valid(20, flits);
        check_eq("same_cycle_credit", W'(flits), W'(2 * (NF + 1)));

        // Credit returned while already full is dropped.
        do_reset();
        step(1'b0, 3'd0, 3'd0, W'($urandom), 1'b1);
        idle(2);
        hold_valid(30, flits);
        check_eq("saturate_flits", W'(flits), W'(NCRED * (NF + 1)));

        // Reset while the second data flit is on the channel.
        do_reset();
        step(1'b1, 3'd7, 3'd0, W'($urandom), 1'b0);
        step(1'b0, 3'd0, 3'd0, W'($urandom), 1'b0);
        step(1'b0, 3'd0, 3'd0, W'($urandom), 1'b0);
        check_eq("pre_rst_busy", W'(busy_dout), W'(1));
        #1;
        reset = 1'b0;
        #1;
        check_eq("midpkt_rst_channel", channel_dout, '0);
        check_eq("midpkt_rst_busy", W'(busy_dout), '0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        idle(NF + 2);
        hold_valid(30, flits);
        check_eq("post_rst_credits", W'(flits), W'(NCRED * (NF + 1)));

        // Random traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), W'($urandom), ($urandom_range(0, 9) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
